// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter
// Shares a single line-granular L2 port between the L1 I-cache and D-cache
// miss ports. The D side wins ties. A saturating starvation counter forces an
// I grant once the D side has taken STARVE_LIMIT grants in a row while the
// I side was waiting. Every output is driven straight from a register.
module l2_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-side client
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-side client
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // L2 port
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  // The counter is 4 bits wide, which covers the full 1..15 limit range.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state_reg,   state_next;
  logic [3:0]            starve_reg,  starve_next;
  logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
  logic [LINE_WIDTH-1:0] wdata_reg,   wdata_next;
  logic                  rd_reg,      rd_next;
  logic                  wr_reg,      wr_next;
  logic [LINE_WIDTH-1:0] i_rdata_reg, i_rdata_next;
  logic [LINE_WIDTH-1:0] d_rdata_reg, d_rdata_next;
  logic                  i_resp_reg,  i_resp_next;
  logic                  d_resp_reg,  d_resp_next;

  logic d_req;
  logic i_starved;

  // A read+write combination from the D side counts as one request (a write).
  assign d_req     = d_read | d_write;
  // The I side is owed a grant once the D side used up its run of grants.
  assign i_starved = i_read && (starve_reg == LIMIT);

  // Next-state, grant latching, data capture and response pulse generation.
  always_comb begin
    state_next   = state_reg;
    starve_next  = starve_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rd_next      = rd_reg;
    wr_next      = wr_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    i_resp_next  = 1'b0;
    d_resp_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (d_req && !i_starved) begin
          // D grant: the write flag wins, so read+write becomes a pure write.
          state_next = BUSY_D;
          addr_next  = d_address;
          wdata_next = d_wdata;
          wr_next    = d_write;
          rd_next    = !d_write;
          if (!i_read) begin
            starve_next = 4'd0;
          end else if (starve_reg != LIMIT) begin
            starve_next = starve_reg + 4'd1;
          end
        end else if (i_read) begin
          state_next  = BUSY_I;
          addr_next   = i_address;
          rd_next     = 1'b1;
          wr_next     = 1'b0;
          starve_next = 4'd0;
        end else begin
          // Nobody waiting on the I side: forget any previous D streak.
          starve_next = 4'd0;
        end
      end

      BUSY_I: begin
        if (l2_resp) begin
          state_next   = DONE_I;
          rd_next      = 1'b0;
          wr_next      = 1'b0;
          i_rdata_next = l2_rdata;
          i_resp_next  = 1'b1;
        end
      end

      BUSY_D: begin
        if (l2_resp) begin
          state_next  = DONE_D;
          // Write completions leave the previously returned line untouched.
          if (rd_reg) begin
            d_rdata_next = l2_rdata;
          end
          rd_next     = 1'b0;
          wr_next     = 1'b0;
          d_resp_next = 1'b1;
        end
      end

      // The response pulse is visible during DONE; the arbiter then frees up.
      DONE_I, DONE_D: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and every output register; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      starve_reg  <= 4'd0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      i_resp_reg  <= 1'b0;
      d_resp_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      starve_reg  <= starve_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rd_reg      <= rd_next;
      wr_reg      <= wr_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      i_resp_reg  <= i_resp_next;
      d_resp_reg  <= d_resp_next;
    end
  end

  assign l2_address = addr_reg;
  assign l2_read    = rd_reg;
  assign l2_write   = wr_reg;
  assign l2_wdata   = wdata_reg;
  assign i_rdata    = i_rdata_reg;
  assign d_rdata    = d_rdata_reg;
  assign i_resp     = i_resp_reg;
  assign d_resp     = d_resp_reg;

endmodule
